// File: rtl/serial_cfg_tx.sv
// serial_cfg_tx: serial programming master for the backend configuration port.
// Latches gain codes on an accepted start and shifts a fixed MSB-first frame
// (header 3'b101, gainA1[2:0], gainA2[1:0]) onto o_sclk/o_sdin.
// Optional build macro SERIAL_CFG_PARITY_EN appends an even-parity bit over
// the five payload bits (header excluded), making the frame 9 bits long.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no frame; waits for i_start, o_done pulses on entry
// LOW    | o_sclk low for DIV cycles, o_sdin holds the current bit
// HIGH   | o_sclk high for DIV cycles, backend samples on the rising edge
// GAP    | lines idle low for GAP cycles before the frame completes
module serial_cfg_tx #(
    parameter int DIV = 4,
    parameter int GAP = 8
) (
    input  logic       i_clk,
    input  logic       i_resetbAll,
    input  logic       i_start,
    input  logic [2:0] i_gainA1,
    input  logic [1:0] i_gainA2,
    output logic       o_sclk,
    output logic       o_sdin,
    output logic       o_busy,
    output logic       o_done
);

`ifdef SERIAL_CFG_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif

    localparam int HW = $clog2(DIV + 1);
    localparam int GW = $clog2(GAP + 1);

    localparam logic [HW-1:0] HALF_LOAD = HW'(DIV - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP - 1);
    localparam logic [3:0]    BIT_LOAD  = 4'(NBITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]       r_state;
    logic [HW-1:0]    r_half_cnt;
    logic [GW-1:0]    r_gap_cnt;
    logic [3:0]       r_bit_cnt;
    // Holds the bits still to be sent after the one currently on o_sdin.
    logic [NBITS-2:0] r_shift;
    logic             r_sclk;
    logic             r_sdin;
    logic             r_busy;
    logic             r_done;

    logic [NBITS-1:0] w_frame;

    // Assemble the frame from the live gain inputs; only used in the accept cycle.
    always_comb begin
`ifdef SERIAL_CFG_PARITY_EN
        w_frame = {3'b101, i_gainA1, i_gainA2, ^{i_gainA1, i_gainA2}};
`else
        w_frame = {3'b101, i_gainA1, i_gainA2};
`endif
    end

    // Frame sequencer: all line outputs are registered so they leave glitch-free.
    always_ff @(posedge i_clk or negedge i_resetbAll) begin
        if (!i_resetbAll) begin
            r_state    <= S_IDLE;
            r_half_cnt <= '0;
            r_gap_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_sclk     <= 1'b0;
            r_sdin     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_LOW;
                        r_half_cnt <= HALF_LOAD;
                        r_bit_cnt  <= BIT_LOAD;
                        r_sdin     <= w_frame[NBITS-1];
                        r_shift    <= w_frame[NBITS-2:0];
                        r_sclk     <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_LOW: begin
                    if (r_half_cnt == '0) begin
                        r_state    <= S_HIGH;
                        r_half_cnt <= HALF_LOAD;
                        r_sclk     <= 1'b1;
                    end else begin
                        r_half_cnt <= r_half_cnt - 1'b1;
                    end
                end
                S_HIGH: begin
                    if (r_half_cnt == '0) begin
                        r_sclk <= 1'b0;
                        if (r_bit_cnt != '0) begin
                            // Next bit goes out on the same edge o_sclk falls.
                            r_state    <= S_LOW;
                            r_half_cnt <= HALF_LOAD;
                            r_bit_cnt  <= r_bit_cnt - 1'b1;
                            r_sdin     <= r_shift[NBITS-2];
                            r_shift    <= {r_shift[NBITS-3:0], 1'b0};
                        end else begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= GAP_LOAD;
                            r_sdin    <= 1'b0;
                        end
                    end else begin
                        r_half_cnt <= r_half_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_sclk  <= 1'b0;
                    r_sdin  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_sclk = r_sclk;
    assign o_sdin = r_sdin;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_serial_cfg_tx.sv
// Testbench for serial_cfg_tx: table-driven frames on a DIV=4/GAP=8 and a
// DIV=1/GAP=1 instance, plus hand sequences for start-while-busy,
// back-to-back start and asynchronous reset mid-frame.
module tb_serial_cfg_tx;

`ifdef SERIAL_CFG_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [2:0] a1;
    logic [1:0] a2;
    logic       sclk0, sdin0, busy0, done0;
    logic       sclk1, sdin1, busy1, done1;

    serial_cfg_tx #(.DIV(4), .GAP(8)) dut0 (
        .i_clk(clk), .i_resetbAll(rst_n), .i_start(start),
        .i_gainA1(a1), .i_gainA2(a2),
        .o_sclk(sclk0), .o_sdin(sdin0), .o_busy(busy0), .o_done(done0)
    );

    serial_cfg_tx #(.DIV(1), .GAP(1)) dut1 (
        .i_clk(clk), .i_resetbAll(rst_n), .i_start(start),
        .i_gainA1(a1), .i_gainA2(a2),
        .o_sclk(sclk1), .o_sdin(sdin1), .o_busy(busy1), .o_done(done1)
    );

    int   sel = 0;
    logic m_sclk, m_sdin, m_busy, m_done;
    assign m_sclk = (sel != 0) ? sclk1 : sclk0;
    assign m_sdin = (sel != 0) ? sdin1 : sdin0;
    assign m_busy = (sel != 0) ? busy1 : busy0;
    assign m_done = (sel != 0) ? done1 : done0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Samples the selected DUT once per cycle (negedge) from the first busy
    // cycle until busy drops; optionally re-pulses start mid-frame or issues
    // a new start in the done cycle.
    task automatic run_mon(input int div, input int repulse_at, input logic b2b,
                           input logic [2:0] na1, input logic [1:0] na2,
                           output logic [8:0] bits, output int nb, output int busy_n,
                           output logic done_at_fall, output int shape_err,
                           output logic timeout);
        logic ps, pd;
        ps = 1'b0; pd = 1'b0;
        bits = '0; nb = 0; busy_n = 0; done_at_fall = 1'b0; shape_err = 0; timeout = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (c == repulse_at) begin
                start = 1'b1; a1 = 3'b000; a2 = 2'b00;
            end else if (c == repulse_at + 1) begin
                start = 1'b0;
            end
            if (!m_busy) begin
                done_at_fall = m_done;
                if (m_sclk || m_sdin) shape_err++;
                if (b2b) begin
                    start = 1'b1; a1 = na1; a2 = na2;
                end
                timeout = 1'b0;
                break;
            end
            if (busy_n < 2 * div * NB) begin
                if (m_sclk !== (((busy_n / div) % 2) == 1)) shape_err++;
            end else if (m_sclk || m_sdin) begin
                shape_err++;
            end
            if (m_done) shape_err++;
            if (m_sclk && !ps) begin
                bits = {bits[7:0], m_sdin};
                nb++;
            end
            if (m_sclk && ps && (m_sdin !== pd)) shape_err++;
            ps = m_sclk; pd = m_sdin;
            busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (m_done) n++;
        end
    endtask

    task automatic frame(input string nm, input int s, input logic [2:0] fa1,
                         input logic [1:0] fa2, input logic [8:0] exp_bits,
                         input int repulse_at);
        logic [8:0] bits;
        int nb, busy_n, shape_err, extra, div, gap;
        logic dn, to;
        sel = s;
        div = (s != 0) ? 1 : 4;
        gap = (s != 0) ? 1 : 8;
        @(negedge clk);
        start = 1'b1; a1 = fa1; a2 = fa2;
        @(negedge clk);
        start = 1'b0;
        run_mon(div, repulse_at, 1'b0, 3'b000, 2'b00, bits, nb, busy_n, dn, shape_err, to);
        chk({nm, "_timeout"}, 32'(to), 32'd0);
        chk({nm, "_bits"}, 32'(bits), 32'(exp_bits));
        chk({nm, "_nbits"}, nb, NB);
        chk({nm, "_busy_len"}, busy_n, 2 * div * NB + gap);
        chk({nm, "_done_at_fall"}, 32'(dn), 32'd1);
        chk({nm, "_shape"}, shape_err, 0);
        count_done(100, extra);
        chk({nm, "_extra_done"}, extra, 0);
    endtask

    typedef struct {
        string      name;
        int         sel;
        logic [2:0] ga1;
        logic [1:0] ga2;
        logic [8:0] exp_bits;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [8:0] bits;
        int nb, busy_n, shape_err, rises, n;
        logic dn, to, ps;

`ifdef SERIAL_CFG_PARITY_EN
        vecs[0] = '{"f110_01", 0, 3'b110, 2'b01, 9'b101_110_01_1};
        vecs[1] = '{"f000_00", 0, 3'b000, 2'b00, 9'b101_000_00_0};
        vecs[2] = '{"f010_11", 0, 3'b010, 2'b11, 9'b101_010_11_1};
        vecs[3] = '{"d1_111_11", 1, 3'b111, 2'b11, 9'b101_111_11_1};
        vecs[4] = '{"d1_000_00", 1, 3'b000, 2'b00, 9'b101_000_00_0};
`else
        vecs[0] = '{"f110_01", 0, 3'b110, 2'b01, 9'h0B9};
        vecs[1] = '{"f000_00", 0, 3'b000, 2'b00, 9'h0A0};
        vecs[2] = '{"f010_11", 0, 3'b010, 2'b11, 9'h0AB};
        vecs[3] = '{"d1_111_11", 1, 3'b111, 2'b11, 9'h0BF};
        vecs[4] = '{"d1_000_00", 1, 3'b000, 2'b00, 9'h0A0};
`endif

        rst_n = 1'b0; start = 1'b0; a1 = '0; a2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_outs0", {28'd0, sclk0, sdin0, busy0, done0}, 32'd0);
        chk("rst_outs1", {28'd0, sclk1, sdin1, busy1, done1}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            frame(vecs[i].name, vecs[i].sel, vecs[i].ga1, vecs[i].ga2, vecs[i].exp_bits, -10);

        // start re-pulsed 10 cycles into a frame with different gains: ignored
        frame("repulse", 0, 3'b110, 2'b01, vecs[0].exp_bits, 10);

        // start in the done cycle: accepted, busy re-rises next cycle
        sel = 0;
        @(negedge clk);
        start = 1'b1; a1 = 3'b110; a2 = 2'b01;
        @(negedge clk);
        start = 1'b0;
        run_mon(4, -10, 1'b1, 3'b011, 2'b10, bits, nb, busy_n, dn, shape_err, to);
        chk("b2b_first_bits", 32'(bits), 32'(vecs[0].exp_bits));
        chk("b2b_first_done", 32'(dn), 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy_rise", 32'(m_busy), 32'd1);
        run_mon(4, -10, 1'b0, 3'b000, 2'b00, bits, nb, busy_n, dn, shape_err, to);
`ifdef SERIAL_CFG_PARITY_EN
        chk("b2b_second_bits", 32'(bits), 32'(9'b101_011_10_1));
`else
        chk("b2b_second_bits", 32'(bits), 32'h0AE);
`endif
        chk("b2b_second_len", busy_n, 8 * NB + 8);
        chk("b2b_second_shape", shape_err, 0);
        count_done(100, n);
        chk("b2b_extra_done", n, 0);

        // async reset during the 3rd HIGH phase
        sel = 0;
        @(negedge clk);
        start = 1'b1; a1 = 3'b110; a2 = 2'b01;
        @(negedge clk);
        start = 1'b0;
        rises = 0; ps = 1'b0;
        for (int c = 0; c < 200 && rises < 3; c++) begin
            @(negedge clk);
            if (sclk0 && !ps) rises++;
            ps = sclk0;
        end
        chk("rst_mid_reached_high3", rises, 3);
        chk("rst_mid_pre", {29'd0, sclk0, sdin0, busy0}, 32'd7);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_async", {29'd0, sclk0, sdin0, busy0}, 32'd0);
        n = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done0) n++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done0 || busy0) n++;
        end
        chk("rst_mid_no_done", n, 0);
        frame("post_rst", 0, 3'b011, 2'b10,
`ifdef SERIAL_CFG_PARITY_EN
              9'b101_011_10_1,
`else
              9'h0AE,
`endif
              -10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
